// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage.
// The master side drives the fetch inputs; the slave side is the stage.
interface decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [XLEN-1:0]  pc;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  pc_out;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic             regwrite;
    logic             memwrite;
    logic             branch;
    logic             jump;
    logic             jalr;
    logic             alusrc;
    logic             alusrc_a;
    logic [1:0]       resultsrc;
    logic [2:0]       immsrc;
    logic [4:0]       alucontrol;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, pc_out, rd, rs1, rs2,
        input  funct3, regwrite, memwrite, branch, jump,
        input  jalr, alusrc, alusrc_a, resultsrc, immsrc,
        input  alucontrol, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, pc_out, rd, rs1, rs2,
        output funct3, regwrite, memwrite, branch, jump,
        output jalr, alusrc, alusrc_a, resultsrc, immsrc,
        output alucontrol, illegal, illegal_cnt
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I(+M) decode stage with valid/ready handshake,
// flush and a saturating illegal-instruction counter.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit SUPPORT_M = 1'b0,
    parameter int CNT_W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic       regwrite;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alusrc;
        logic       alusrc_a;
        logic [1:0] resultsrc;
        logic [2:0] immsrc;
        logic [4:0] alucontrol;
        logic       illegal;
    } ctl_t;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;

    localparam logic [6:0] F7_0 = 7'b0000000;
    localparam logic [6:0] F7_A = 7'b0100000;
    localparam logic [6:0] F7_M = 7'b0000001;

    function automatic logic [4:0] alu_base(
        input logic [2:0] f
    );
        logic [4:0] a;
        a = ALU_ADD;
        unique case (f)
            3'b000: a = ALU_ADD;
            3'b001: a = ALU_SLL;
            3'b010: a = ALU_SLT;
            3'b011: a = ALU_SLTU;
            3'b100: a = ALU_XOR;
            3'b101: a = ALU_SRL;
            3'b110: a = ALU_OR;
            3'b111: a = ALU_AND;
            default: a = ALU_ADD;
        endcase
        return a;
    endfunction

    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;

    assign op = bus.instr[6:0];
    assign f3 = bus.instr[14:12];
    assign f7 = bus.instr[31:25];

    ctl_t dc;

    always_comb begin
        dc = '0;
        unique case (1'b1)
            op == 7'b0110011: begin
                dc.regwrite = 1'b1;
                unique case (1'b1)
                    f7 == F7_0:
                        dc.alucontrol = alu_base(f3);
                    f7 == F7_A && f3 == 3'b000:
                        dc.alucontrol = ALU_SUB;
                    f7 == F7_A && f3 == 3'b101:
                        dc.alucontrol = ALU_SRA;
                    SUPPORT_M && f7 == F7_M:
                        dc.alucontrol = {2'b10, f3};
                    default:
                        dc.illegal = 1'b1;
                endcase
            end
            op == 7'b0010011: begin
                dc.regwrite   = 1'b1;
                dc.alusrc     = 1'b1;
                dc.alucontrol = alu_base(f3);
                if (f3 == 3'b001 && f7 != F7_0)
                    dc.illegal = 1'b1;
                if (f3 == 3'b101) begin
                    if (bus.instr[30])
                        dc.alucontrol = ALU_SRA;
                    if (f7 != F7_0 && f7 != F7_A)
                        dc.illegal = 1'b1;
                end
            end
            op == 7'b0000011: begin
                dc.regwrite  = 1'b1;
                dc.alusrc    = 1'b1;
                dc.resultsrc = 2'b01;
                dc.illegal   = f3 == 3'b011 ||
                               f3 == 3'b110 ||
                               f3 == 3'b111;
            end
            op == 7'b0100011: begin
                dc.memwrite = 1'b1;
                dc.alusrc   = 1'b1;
                dc.immsrc   = 3'b001;
                dc.illegal  = f3 > 3'b010;
            end
            op == 7'b1100011: begin
                dc.branch     = 1'b1;
                dc.immsrc     = 3'b010;
                dc.alucontrol = ALU_SUB;
                dc.illegal    = f3 == 3'b010 ||
                                f3 == 3'b011;
            end
            op == 7'b1101111: begin
                dc.regwrite  = 1'b1;
                dc.jump      = 1'b1;
                dc.immsrc    = 3'b011;
                dc.resultsrc = 2'b10;
            end
            op == 7'b1100111: begin
                dc.regwrite  = 1'b1;
                dc.jump      = 1'b1;
                dc.jalr      = 1'b1;
                dc.alusrc    = 1'b1;
                dc.resultsrc = 2'b10;
                dc.illegal   = f3 != 3'b000;
            end
            op == 7'b0110111: begin
                dc.regwrite  = 1'b1;
                dc.immsrc    = 3'b100;
                dc.resultsrc = 2'b11;
            end
            op == 7'b0010111: begin
                dc.regwrite = 1'b1;
                dc.immsrc   = 3'b100;
                dc.alusrc   = 1'b1;
                dc.alusrc_a = 1'b1;
            end
            default:
                dc.illegal = 1'b1;
        endcase
        // Illegal bundles must never cause side effects downstream.
        if (dc.illegal) begin
            dc         = '0;
            dc.illegal = 1'b1;
        end
    end

    logic             valid_q;
    ctl_t             ctl_q;
    logic [XLEN-1:0]  pc_q;
    logic [31:0]      ins_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             take;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept = bus.in_valid && bus.in_ready;
    assign take   = accept && !bus.flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            pc_q    <= '0;
            ins_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (take) begin
                valid_q <= 1'b1;
                ctl_q   <= dc;
                pc_q    <= bus.pc;
                ins_q   <= bus.instr;
            end else if (bus.flush || bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (take && dc.illegal && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out_valid   = valid_q;
    assign bus.pc_out      = pc_q;
    assign bus.rd          = ins_q[11:7];
    assign bus.rs1         = ins_q[19:15];
    assign bus.rs2         = ins_q[24:20];
    assign bus.funct3      = ins_q[14:12];
    assign bus.regwrite    = ctl_q.regwrite;
    assign bus.memwrite    = ctl_q.memwrite;
    assign bus.branch      = ctl_q.branch;
    assign bus.jump        = ctl_q.jump;
    assign bus.jalr        = ctl_q.jalr;
    assign bus.alusrc      = ctl_q.alusrc;
    assign bus.alusrc_a    = ctl_q.alusrc_a;
    assign bus.resultsrc   = ctl_q.resultsrc;
    assign bus.immsrc      = ctl_q.immsrc;
    assign bus.alucontrol  = ctl_q.alucontrol;
    assign bus.illegal     = ctl_q.illegal;
    assign bus.illegal_cnt = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (RV32I/8-bit count and
// RV32IM/2-bit count) driven in lockstep against a reference model.
module tb_decode_stage;
    typedef struct packed {
        logic [4:0] alu;
        logic [2:0] imm;
        logic [1:0] rs;
        logic rw, mw, br, jp, jr, asrc, asrca, ill;
    } ctl_t;

    typedef struct packed {
        logic        v;
        logic        r;
        logic [31:0] pc;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        ctl_t        c;
        logic [7:0]  cnt;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic ill0, ill1;
        logic [4:0] alu0, alu1;
        logic rw;
        logic [2:0] imm;
        logic [1:0] rs;
    } vec_t;

    localparam logic [4:0] BASE [8] =
        '{5'd0, 5'd7, 5'd5, 5'd6, 5'd4, 5'd8, 5'd3, 5'd2};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic iv = 1'b0, ordy = 1'b1, fl = 1'b0;
    logic [31:0] ins = '0, pcv = '0;

    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32), .CNT_W(8)) ia ();
    decode_stage_if #(.XLEN(32), .CNT_W(2)) ib ();

    assign ia.in_valid = iv;  assign ib.in_valid = iv;
    assign ia.out_ready = ordy; assign ib.out_ready = ordy;
    assign ia.flush = fl;     assign ib.flush = fl;
    assign ia.instr = ins;    assign ib.instr = ins;
    assign ia.pc = pcv;       assign ib.pc = pcv;

    decode_stage #(.XLEN(32), .SUPPORT_M(1'b0), .CNT_W(8))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    decode_stage #(.XLEN(32), .SUPPORT_M(1'b1), .CNT_W(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

    obs_t obs [2];
    assign obs[0] = {ia.out_valid, ia.in_ready, ia.pc_out,
        ia.rd, ia.rs1, ia.rs2, ia.funct3,
        ia.alucontrol, ia.immsrc, ia.resultsrc,
        ia.regwrite, ia.memwrite, ia.branch, ia.jump,
        ia.jalr, ia.alusrc, ia.alusrc_a, ia.illegal,
        ia.illegal_cnt};
    assign obs[1] = {ib.out_valid, ib.in_ready, ib.pc_out,
        ib.rd, ib.rs1, ib.rs2, ib.funct3,
        ib.alucontrol, ib.immsrc, ib.resultsrc,
        ib.regwrite, ib.memwrite, ib.branch, ib.jump,
        ib.jalr, ib.alusrc, ib.alusrc_a, ib.illegal,
        6'b0, ib.illegal_cnt};

    int checks = 0;
    int errors = 0;

    bit          mv   [2];
    logic [31:0] mi   [2];
    logic [31:0] mp   [2];
    ctl_t        mctl [2];
    int          mc   [2];
    int          cmax [2] = '{255, 3};

    task automatic chk(string nm, int k,
                       logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h",
                     nm, k, act, exp);
        end
    endtask

    function automatic ctl_t ref_ctl(logic [31:0] i, bit m);
        ctl_t c;
        logic [2:0] f3;
        logic [6:0] f7;
        c  = '0;
        f3 = i[14:12];
        f7 = i[31:25];
        case (i[6:0])
            7'h33: begin
                c.rw = 1;
                if (m && f7 == 7'h01) c.alu = 5'd16 + 5'(f3);
                else if (f7 == 7'h00) c.alu = BASE[f3];
                else if (f7 == 7'h20 && f3 == 0) c.alu = 1;
                else if (f7 == 7'h20 && f3 == 5) c.alu = 9;
                else c.ill = 1;
            end
            7'h13: begin
                c.rw = 1; c.asrc = 1; c.alu = BASE[f3];
                if (f3 == 1 && f7 != 0) c.ill = 1;
                if (f3 == 5) begin
                    if (f7 == 7'h20) c.alu = 9;
                    else if (f7 != 0) c.ill = 1;
                end
            end
            7'h03: begin
                c.rw = 1; c.asrc = 1; c.rs = 1;
                c.ill = (f3 == 3 || f3 == 6 || f3 == 7);
            end
            7'h23: begin
                c.mw = 1; c.asrc = 1; c.imm = 1;
                c.ill = f3 > 2;
            end
            7'h63: begin
                c.br = 1; c.imm = 2; c.alu = 1;
                c.ill = (f3 == 2 || f3 == 3);
            end
            7'h6F: begin
                c.rw = 1; c.jp = 1; c.imm = 3; c.rs = 2;
            end
            7'h67: begin
                c.rw = 1; c.jp = 1; c.jr = 1; c.asrc = 1;
                c.rs = 2; c.ill = f3 != 0;
            end
            7'h37: begin c.rw = 1; c.imm = 4; c.rs = 3; end
            7'h17: begin
                c.rw = 1; c.imm = 4; c.asrc = 1; c.asrca = 1;
            end
            default: c.ill = 1;
        endcase
        if (c.ill) begin
            c = '0;
            c.ill = 1;
        end
        return c;
    endfunction

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            chk("valid", k, 32'(obs[k].v), 32'(mv[k]));
            chk("ready", k, 32'(obs[k].r), 32'(!mv[k] || ordy));
            chk("cnt", k, 32'(obs[k].cnt), mc[k]);
            if (mv[k]) begin
                chk("pc", k, obs[k].pc, mp[k]);
                chk("rd", k, 32'(obs[k].rd), 32'(mi[k][11:7]));
                chk("rs1", k, 32'(obs[k].rs1), 32'(mi[k][19:15]));
                chk("rs2", k, 32'(obs[k].rs2), 32'(mi[k][24:20]));
                chk("f3", k, 32'(obs[k].f3), 32'(mi[k][14:12]));
                chk("ctl", k, 32'(obs[k].c), 32'(mctl[k]));
            end
        end
    endtask

    task automatic tick();
        bit acc [2];
        for (int k = 0; k < 2; k++)
            acc[k] = iv && (!mv[k] || ordy);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (acc[k] && !fl) begin
                mv[k]   = 1;
                mi[k]   = ins;
                mp[k]   = pcv;
                mctl[k] = ref_ctl(ins, k == 1);
                if (mctl[k].ill && mc[k] < cmax[k])
                    mc[k]++;
            end else if (fl || ordy) begin
                mv[k] = 0;
            end
        end
        compare();
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mv[k] = 0; mc[k] = 0; mi[k] = '0;
            mp[k] = '0; mctl[k] = '0;
        end
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23,
            7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
        logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 9) != 0)
            r[6:0] = ops[$urandom_range(0, 9)];
        f7s[3] = 7'($urandom);
        r[31:25] = f7s[$urandom_range(0, 3)];
        return r;
    endfunction

    vec_t tbl [16];
    logic [4:0] hold_rd;
    int cnt_a;

    initial begin
        tbl[0]  = '{32'h002081B3, 0, 0, 0, 0, 1, 0, 0};
        tbl[1]  = '{32'h402081B3, 0, 0, 1, 1, 1, 0, 0};
        tbl[2]  = '{32'h123452B7, 0, 0, 0, 0, 1, 4, 3};
        tbl[3]  = '{32'h00500093, 0, 0, 0, 0, 1, 0, 0};
        tbl[4]  = '{32'h022081B3, 1, 0, 0, 16, 0, 0, 0};
        tbl[5]  = '{32'hFFFFFFFF, 1, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{32'h4020D093, 0, 0, 9, 9, 1, 0, 0};
        tbl[7]  = '{32'h00209093, 0, 0, 7, 7, 1, 0, 0};
        tbl[8]  = '{32'h40209093, 1, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{32'h0000A083, 0, 0, 0, 0, 1, 0, 1};
        tbl[10] = '{32'h0000B083, 1, 1, 0, 0, 0, 0, 0};
        tbl[11] = '{32'h0020A023, 0, 0, 0, 0, 0, 1, 0};
        tbl[12] = '{32'h00208063, 0, 0, 1, 1, 0, 2, 0};
        tbl[13] = '{32'h0000006F, 0, 0, 0, 0, 1, 3, 2};
        tbl[14] = '{32'h000080E7, 0, 0, 0, 0, 1, 0, 2};
        tbl[15] = '{32'h00001097, 0, 0, 0, 0, 1, 4, 0};

        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, 32'(obs[k].v), 0);
            chk("rst_ready", k, 32'(obs[k].r), 1);
            chk("rst_cnt", k, 32'(obs[k].cnt), 0);
            chk("rst_ctl", k, 32'(obs[k].c), 0);
            chk("rst_pc", k, obs[k].pc, 0);
        end
        #11 rst_n = 1'b1;

        foreach (tbl[t]) begin
            iv = 1; ordy = 1; fl = 0;
            ins = tbl[t].instr;
            pcv = $urandom & 32'hFFFF_FFFC;
            tick();
            chk("t_ill", 0, 32'(obs[0].c.ill), 32'(tbl[t].ill0));
            chk("t_ill", 1, 32'(obs[1].c.ill), 32'(tbl[t].ill1));
            chk("t_alu", 0, 32'(obs[0].c.alu), 32'(tbl[t].alu0));
            chk("t_alu", 1, 32'(obs[1].c.alu), 32'(tbl[t].alu1));
            chk("t_rw", 0, 32'(obs[0].c.rw), 32'(tbl[t].rw));
            chk("t_imm", 0, 32'(obs[0].c.imm), 32'(tbl[t].imm));
            chk("t_rs", 0, 32'(obs[0].c.rs), 32'(tbl[t].rs));
        end

        // backpressure: bundle held, next instr waits
        ins = 32'h002081B3; tick();
        hold_rd = 5'd3;
        ins = 32'h00500093; ordy = 0;
        repeat (3) begin
            tick();
            chk("bp_ready", 0, 32'(obs[0].r), 0);
            chk("bp_rd", 0, 32'(obs[0].rd), 32'(hold_rd));
        end
        ordy = 1; tick();
        chk("bp_next_rd", 0, 32'(obs[0].rd), 1);

        // flush in the accept cycle of an illegal instr
        cnt_a = 32'(obs[0].cnt);
        ins = 32'hFFFFFFFF; fl = 1; tick();
        chk("fl_valid", 0, 32'(obs[0].v), 0);
        chk("fl_cnt", 0, 32'(obs[0].cnt), cnt_a);
        fl = 0;

        // counter saturation on the 2-bit instance
        repeat (5) tick();
        chk("sat_cnt", 1, 32'(obs[1].cnt), 3);
        chk("cnt_a", 0, 32'(obs[0].cnt), cnt_a + 5);

        // async reset while a bundle is valid
        ins = 32'h002081B3; tick();
        #2 rst_n = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, 32'(obs[k].v), 0);
            chk("arst_cnt", k, 32'(obs[k].cnt), 0);
        end
        model_reset();
        #2 rst_n = 1;

        for (int n = 0; n < 500; n++) begin
            iv   = $urandom_range(0, 3) != 0;
            ordy = $urandom_range(0, 2) != 0;
            fl   = $urandom_range(0, 15) == 0;
            ins  = rnd_instr();
            pcv  = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
